lbm_field_reader: RTL and testbench
===================================

# lbm_field_reader

Read-out engine for the LBM_DE2 macroscopic field memories: density, ux and uy. When a timestep completes, it sweeps every lattice cell in address order and fetches p, ux and uy through a shared 1-cycle-latency read port. It then streams them, preceded by one header word, onto a valid/ready word stream toward the host link (UART/JTAG bridge). It is the reader counterpart of the collision/streaming datapath that writes the field memories.

## Interface
- GRID_DIM, 16*16, lattice cells swept per frame
- MAX_TIME, 8, maximum timestep count
- TIME_COUNT_WIDTH, $clog2(MAX_TIME), timestep field width
- DATA_WIDTH, 32, field word width (signed Q8.24, passed through unmodified)
- ADDRESS_WIDTH, $clog2(GRID_DIM), cell address width
- CLOCK_50  in  1  sole clock, rising edge
- RESET  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse: field memories hold a complete timestep
- time_step  in  TIME_COUNT_WIDTH  timestep index, sampled with start
- mem_rd_en  out  1  read strobe to the p/ux/uy memories
- mem_rd_addr  out  ADDRESS_WIDTH  cell address shared by all three memories
- p_mem_data_out  in  DATA_WIDTH  density read data, valid the cycle after mem_rd_en
- ux_mem_data_out  in  DATA_WIDTH  x-velocity read data, same timing
- uy_mem_data_out  in  DATA_WIDTH  y-velocity read data, same timing
- out_data  out  DATA_WIDTH  stream word
- out_valid  out  1  out_data valid
- out_ready  in  1  sink accepts the word when out_valid && out_ready at a rising edge
- out_last  out  1  marks the final word of a frame (uy of cell GRID_DIM-1)
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after the frame's last word is accepted

## Operation
- States: IDLE, HEADER, FETCH, CAPTURE, EMIT_P, EMIT_UX, EMIT_UY, DONE.
- IDLE
  - start=1 latches time_step and clears the cell counter to 0.
  - Transition to HEADER.
- HEADER
  - out_valid=1.
  - out_data = {8'hA5, zeros, time_step_latched}; time_step occupies bits [TIME_COUNT_WIDTH-1:0].
  - On acceptance, go to FETCH.
- FETCH
  - mem_rd_en=1 and mem_rd_addr=cell for exactly one cycle.
  - Unconditionally go to CAPTURE.
- CAPTURE
  - Register p_mem_data_out, ux_mem_data_out and uy_mem_data_out into three holding registers.
  - Go to EMIT_P.
- EMIT_P, EMIT_UX, EMIT_UY
  - out_valid=1; out_data is the corresponding holding register.
  - On acceptance, advance to the next field.
  - After EMIT_UY is accepted: if cell==GRID_DIM-1, go to DONE; otherwise increment cell and go to FETCH.
- out_last=1 only in EMIT_UY with cell==GRID_DIM-1.
- DONE
  - done=1 for one cycle.
  - Go to IDLE.
- busy=1 in every state except IDLE.
- Handshake rules:
  - Once out_valid rises, out_data, out_last and out_valid stay stable until accepted.
  - out_valid never depends combinationally on out_ready.
- start while busy is ignored: no relatch, no restart.
- start in the same cycle as DONE is ignored. start is honored only in IDLE.
- The cell counter wraps only through DONE→IDLE. It never exceeds GRID_DIM-1.
- mem_rd_en is never asserted outside FETCH. Memories are read at most once per cell.
- Frame length: 1 + 3*GRID_DIM words. This is 769 for 16*16.

## Timing
- Reset: state=IDLE, cell=0, holding and time registers=0.
- Reset values of all outputs: out_valid=0, out_last=0, out_data=0, mem_rd_en=0, mem_rd_addr=0, busy=0, done=0.
- RESET asserted mid-frame:
  - State returns to IDLE at that edge.
  - out_valid drops with no partial-frame completion and no done pulse.
- start sampled at edge N → out_valid (header) high during cycle N+1.
- Best-case timing with out_ready held high:
  - 5 cycles per cell: FETCH, CAPTURE, EMIT_P, EMIT_UX, EMIT_UY.
  - Full frame: start edge to done = 2 + 5*GRID_DIM cycles, which is 1282 for 256 cells.
- Read data is sampled in CAPTURE, one cycle after FETCH. The memory must present data with 1-cycle latency.
- Backpressure stalls only the EMIT/HEADER states. It adds exactly one cycle per cycle of out_ready=0.

## Test plan
- Reset, then idle 10 cycles with out_ready=1 → out_valid, mem_rd_en, busy and done all remain 0.
- Preload p[i]=i, ux[i]=0x100+i, uy[i]=0x200+i; start with time_step=5 and out_ready=1. Required response:
  - Words: 0xA5000005, then 0,0x100,0x200,1,0x101,0x201,…
  - 769 words total; out_last only on 0x2FF.
  - done exactly 1282 cycles after start.
- Random out_ready (≈50%) on the same frame → identical word sequence, out_data held stable while stalled, no duplicated or dropped words.
- Pulse start again at cell 37 mid-frame → ignored: the header appears once, and time_step stays at the first latched value.
- Assert RESET for one cycle at cell 100 during EMIT_UX stall. Required response:
  - Next cycle out_valid=0, busy=0, no done.
  - A fresh start produces a complete frame beginning from cell 0.
- Check every FETCH cycle: mem_rd_addr equals the cell index. mem_rd_en count per frame = 256.

Source files
------------

// File: rtl/lbm_field_reader.sv
// lbm_field_reader
// Sweeps the p/ux/uy field memories once per finished timestep and streams
// a header word followed by (p, ux, uy) for every lattice cell in address
// order onto a valid/ready word stream toward the host link.
module lbm_field_reader #(
    parameter int GRID_DIM         = 16*16,
    parameter int MAX_TIME         = 8,
    parameter int TIME_COUNT_WIDTH = $clog2(MAX_TIME),
    parameter int DATA_WIDTH       = 32,
    parameter int ADDRESS_WIDTH    = $clog2(GRID_DIM)
) (
    input  logic                        CLOCK_50,
    input  logic                        RESET,
    input  logic                        start,
    input  logic [TIME_COUNT_WIDTH-1:0] time_step,
    output logic                        mem_rd_en,
    output logic [ADDRESS_WIDTH-1:0]    mem_rd_addr,
    input  logic [DATA_WIDTH-1:0]       p_mem_data_out,
    input  logic [DATA_WIDTH-1:0]       ux_mem_data_out,
    input  logic [DATA_WIDTH-1:0]       uy_mem_data_out,
    output logic [DATA_WIDTH-1:0]       out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_last,
    output logic                        busy,
    output logic                        done
);

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        FETCH,
        CAPTURE,
        EMIT_P,
        EMIT_UX,
        EMIT_UY,
        DONE
    } state_t;

    localparam logic [ADDRESS_WIDTH-1:0] LAST_CELL = ADDRESS_WIDTH'(GRID_DIM - 1);
    localparam logic [7:0]               HEADER_TAG = 8'hA5;

    // Registered FSM state and datapath
    state_t                        state_q;
    logic [ADDRESS_WIDTH-1:0]      cell_q;
    logic [TIME_COUNT_WIDTH-1:0]   time_q;
    logic [DATA_WIDTH-1:0]         pHold_q;
    logic [DATA_WIDTH-1:0]         uxHold_q;
    logic [DATA_WIDTH-1:0]         uyHold_q;
    logic                          out_valid_q;
    logic                          out_last_q;
    logic                          mem_rd_en_q;
    logic                          busy_q;
    logic                          done_q;

    // Helper decodes (no dependence of out_valid on out_ready)
    logic                          wordAccepted;
    logic                          isLastCell;
    logic [DATA_WIDTH-1:0]         headerWord;
    logic [DATA_WIDTH-1:0]         streamWord;

    // Decode handshake completion, end-of-sweep and the header layout
    always_comb begin
        wordAccepted = out_valid_q && out_ready;
        isLastCell   = (cell_q == LAST_CELL);
        headerWord   = '0;
        headerWord[DATA_WIDTH-1 -: 8]       = HEADER_TAG;
        headerWord[TIME_COUNT_WIDTH-1:0]    = time_q;
    end

    // Select the stream word purely from registered state so it holds while stalled
    always_comb begin
        streamWord = '0;
        case (state_q)
            HEADER:  streamWord = headerWord;
            EMIT_P:  streamWord = pHold_q;
            EMIT_UX: streamWord = uxHold_q;
            EMIT_UY: streamWord = uyHold_q;
            default: streamWord = '0;
        endcase
    end

    // Frame sequencer: header, then FETCH/CAPTURE/EMIT x3 per cell, then a done pulse
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q     <= IDLE;
            cell_q      <= '0;
            time_q      <= '0;
            pHold_q     <= '0;
            uxHold_q    <= '0;
            uyHold_q    <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            mem_rd_en_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        time_q      <= time_step;
                        cell_q      <= '0;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= HEADER;
                    end
                end

                HEADER: begin
                    if (wordAccepted) begin
                        out_valid_q <= 1'b0;
                        mem_rd_en_q <= 1'b1;
                        state_q     <= FETCH;
                    end
                end

                FETCH: begin
                    mem_rd_en_q <= 1'b0;
                    state_q     <= CAPTURE;
                end

                CAPTURE: begin
                    pHold_q     <= p_mem_data_out;
                    uxHold_q    <= ux_mem_data_out;
                    uyHold_q    <= uy_mem_data_out;
                    out_valid_q <= 1'b1;
                    state_q     <= EMIT_P;
                end

                EMIT_P: begin
                    if (wordAccepted) begin
                        state_q <= EMIT_UX;
                    end
                end

                EMIT_UX: begin
                    if (wordAccepted) begin
                        out_last_q <= isLastCell;
                        state_q    <= EMIT_UY;
                    end
                end

                EMIT_UY: begin
                    if (wordAccepted) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        if (isLastCell) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            cell_q      <= cell_q + ADDRESS_WIDTH'(1);
                            mem_rd_en_q <= 1'b1;
                            state_q     <= FETCH;
                        end
                    end
                end

                DONE: begin
                    cell_q  <= '0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_rd_en   = mem_rd_en_q;
    assign mem_rd_addr = cell_q;
    assign out_data    = streamWord;
    assign out_valid   = out_valid_q;
    assign out_last    = out_last_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_lbm_field_reader.sv
// tb_lbm_field_reader
// Drives whole frames through lbm_field_reader against a 1-cycle-latency
// memory model and compares every streamed word with a scoreboard queue.
module tb_lbm_field_reader;

    localparam int GRID      = 256;
    localparam int FRAME_LEN = 1 + 3*GRID;
    localparam int LIMIT     = 10000;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } sbEntry_t;

    typedef struct {
        logic [2:0]  ts;
        int          readyMode;
        int          pattern;
        logic [31:0] expHeader;
        int          expDoneCycle;
        int          expWords;
    } frame_t;

    logic        CLOCK_50 = 1'b0;
    logic        RESET = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  time_step = 3'd0;
    logic        mem_rd_en;
    logic [7:0]  mem_rd_addr;
    logic [31:0] p_mem_data_out;
    logic [31:0] ux_mem_data_out;
    logic [31:0] uy_mem_data_out;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_last;
    logic        busy;
    logic        done;

    logic [31:0] pMem  [GRID];
    logic [31:0] uxMem [GRID];
    logic [31:0] uyMem [GRID];

    sbEntry_t    sbQueue[$];
    frame_t      frameTable[4];
    int          checks = 0;
    int          errors = 0;

    lbm_field_reader dut (
        .CLOCK_50        (CLOCK_50),
        .RESET           (RESET),
        .start           (start),
        .time_step       (time_step),
        .mem_rd_en       (mem_rd_en),
        .mem_rd_addr     (mem_rd_addr),
        .p_mem_data_out  (p_mem_data_out),
        .ux_mem_data_out (ux_mem_data_out),
        .uy_mem_data_out (uy_mem_data_out),
        .out_data        (out_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_last        (out_last),
        .busy            (busy),
        .done            (done)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Field memories: data appears the cycle after a read strobe, garbage otherwise
    always @(posedge CLOCK_50) begin
        if (mem_rd_en) begin
            p_mem_data_out  <= pMem[mem_rd_addr];
            ux_mem_data_out <= uxMem[mem_rd_addr];
            uy_mem_data_out <= uyMem[mem_rd_addr];
        end else begin
            p_mem_data_out  <= 32'hDEAD_0000;
            ux_mem_data_out <= 32'hDEAD_1111;
            uy_mem_data_out <= 32'hDEAD_2222;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic loadMemories(input int pattern);
        for (int i = 0; i < GRID; i++) begin
            if (pattern == 0) begin
                pMem[i]  = 32'(i);
                uxMem[i] = 32'h100 + 32'(i);
                uyMem[i] = 32'h200 + 32'(i);
            end else begin
                pMem[i]  = $urandom;
                uxMem[i] = $urandom;
                uyMem[i] = $urandom;
            end
        end
    endtask

    task automatic pushFrame(input logic [2:0] ts);
        sbQueue.push_back('{data: {8'hA5, 21'd0, ts}, last: 1'b0});
        for (int c = 0; c < GRID; c++) begin
            sbQueue.push_back('{data: pMem[c],  last: 1'b0});
            sbQueue.push_back('{data: uxMem[c], last: 1'b0});
            sbQueue.push_back('{data: uyMem[c], last: (c == GRID - 1)});
        end
    endtask

    // Runs one frame; optionally pulses start again at injectCell or resets during ux of resetCell
    task automatic applyStimulus(input frame_t f, input int injectCell, input int resetCell);
        int          cycle;
        int          words;
        int          fetchCount;
        int          doneCycle;
        logic        prevStall;
        logic [31:0] prevData;
        logic        prevLast;
        logic [31:0] firstWord;
        logic        finished;
        logic        injected;
        logic        injectPending;
        sbEntry_t    e;

        words = 0; fetchCount = 0; doneCycle = 0; firstWord = 32'd0;
        prevStall = 1'b0; prevData = 32'd0; prevLast = 1'b0;
        finished = 1'b0; injected = 1'b0; injectPending = 1'b0;
        sbQueue.delete();
        loadMemories(f.pattern);
        pushFrame(f.ts);

        @(posedge CLOCK_50); #1;
        start     = 1'b1;
        time_step = f.ts;
        out_ready = (f.readyMode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        @(posedge CLOCK_50); #1;
        start = 1'b0;
        cycle = 1;

        while (!finished && cycle <= LIMIT) begin
            @(negedge CLOCK_50);
            if (cycle == 1) checkOutput("headerLatency", 32'(out_valid), 32'd1);
            if (prevStall) begin
                checkOutput("stallValid", 32'(out_valid), 32'd1);
                checkOutput("stallData", out_data, prevData);
                checkOutput("stallLast", 32'(out_last), 32'(prevLast));
            end
            if (mem_rd_en) begin
                checkOutput("fetchAddr", 32'(mem_rd_addr), 32'(fetchCount));
                if (injectCell >= 0 && !injected && fetchCount == injectCell) injectPending = 1'b1;
                fetchCount++;
            end
            if (out_valid && out_ready) begin
                if (sbQueue.size() == 0) begin
                    checkOutput("sbUnderflow", 32'd1, 32'd0);
                end else begin
                    e = sbQueue.pop_front();
                    checkOutput("streamData", out_data, e.data);
                    checkOutput("streamLast", 32'(out_last), 32'(e.last));
                end
                if (words == 0) firstWord = out_data;
                words++;
            end
            prevStall = out_valid && !out_ready;
            prevData  = out_data;
            prevLast  = out_last;

            if (done) begin
                doneCycle = cycle;
                finished  = 1'b1;
            end else if (resetCell >= 0 && out_valid && !out_ready && words == 3*resetCell + 2) begin
                @(posedge CLOCK_50); #1;
                RESET = 1'b1;
                @(posedge CLOCK_50); #1;
                RESET = 1'b0;
                out_ready = 1'b1;
                @(negedge CLOCK_50);
                checkOutput("resetValid", 32'(out_valid), 32'd0);
                checkOutput("resetBusy", 32'(busy), 32'd0);
                checkOutput("resetDone", 32'(done), 32'd0);
                checkOutput("resetLast", 32'(out_last), 32'd0);
                checkOutput("resetRdEn", 32'(mem_rd_en), 32'd0);
                checkOutput("resetAddr", 32'(mem_rd_addr), 32'd0);
                repeat (5) begin
                    @(negedge CLOCK_50);
                    checkOutput("noDoneAfterReset", 32'(done | busy | out_valid), 32'd0);
                end
                sbQueue.delete();
                return;
            end

            if (!finished) begin
                @(posedge CLOCK_50); #1;
                cycle++;
                start = 1'b0;
                if (injectPending) begin
                    start         = 1'b1;
                    time_step     = ~f.ts;
                    injectPending = 1'b0;
                    injected      = 1'b1;
                end
                if (resetCell >= 0 && words == 3*resetCell + 2) out_ready = 1'b0;
                else if (f.readyMode == 0)                    out_ready = 1'b1;
                else                                          out_ready = 1'($urandom_range(0, 1));
            end
        end

        checkOutput("frameDoneSeen", 32'(finished), 32'd1);
        checkOutput("frameWords", 32'(words), 32'(f.expWords));
        checkOutput("frameFetches", 32'(fetchCount), 32'(GRID));
        checkOutput("sbEmpty", 32'(sbQueue.size()), 32'd0);
        checkOutput("headerWord", firstWord, f.expHeader);
        if (f.expDoneCycle > 0) checkOutput("doneCycle", 32'(doneCycle), 32'(f.expDoneCycle));
        if (injectCell >= 0) checkOutput("injectApplied", 32'(injected), 32'd1);

        @(posedge CLOCK_50); #1;
        start     = 1'b0;
        out_ready = 1'b1;
        @(negedge CLOCK_50);
        checkOutput("donePulseWidth", 32'(done), 32'd0);
        checkOutput("idleBusy", 32'(busy), 32'd0);
        checkOutput("idleValid", 32'(out_valid), 32'd0);
    endtask

    // Test sequence: reset/idle checks, table of frames, then the multi-cycle corner cases
    initial begin
        frame_t special;

        frameTable[0] = '{ts: 3'd5, readyMode: 0, pattern: 0, expHeader: 32'hA500_0005, expDoneCycle: 1282, expWords: FRAME_LEN};
        frameTable[1] = '{ts: 3'd5, readyMode: 1, pattern: 0, expHeader: 32'hA500_0005, expDoneCycle: 0,    expWords: FRAME_LEN};
        frameTable[2] = '{ts: 3'd7, readyMode: 0, pattern: 1, expHeader: 32'hA500_0007, expDoneCycle: 1282, expWords: FRAME_LEN};
        frameTable[3] = '{ts: 3'd0, readyMode: 1, pattern: 1, expHeader: 32'hA500_0000, expDoneCycle: 0,    expWords: FRAME_LEN};

        RESET     = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        checkOutput("rstValid", 32'(out_valid), 32'd0);
        checkOutput("rstLast", 32'(out_last), 32'd0);
        checkOutput("rstData", out_data, 32'd0);
        checkOutput("rstRdEn", 32'(mem_rd_en), 32'd0);
        checkOutput("rstAddr", 32'(mem_rd_addr), 32'd0);
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstDone", 32'(done), 32'd0);
        @(posedge CLOCK_50); #1;
        RESET = 1'b0;

        repeat (10) begin
            @(negedge CLOCK_50);
            checkOutput("idleValid", 32'(out_valid), 32'd0);
            checkOutput("idleRdEn", 32'(mem_rd_en), 32'd0);
            checkOutput("idleBusy", 32'(busy), 32'd0);
            checkOutput("idleDone", 32'(done), 32'd0);
        end

        for (int i = 0; i < 4; i++) begin
            $display("[TB] frame %0d: ts=%0d readyMode=%0d pattern=%0d", i, frameTable[i].ts, frameTable[i].readyMode, frameTable[i].pattern);
            applyStimulus(frameTable[i], -1, -1);
        end

        $display("[TB] start pulsed again at cell 37");
        special = '{ts: 3'd3, readyMode: 0, pattern: 0, expHeader: 32'hA500_0003, expDoneCycle: 1282, expWords: FRAME_LEN};
        applyStimulus(special, 37, -1);

        $display("[TB] reset during ux stall at cell 100");
        special = '{ts: 3'd6, readyMode: 0, pattern: 0, expHeader: 32'hA500_0006, expDoneCycle: 0, expWords: FRAME_LEN};
        applyStimulus(special, -1, 100);

        $display("[TB] fresh frame after mid-frame reset");
        special = '{ts: 3'd1, readyMode: 1, pattern: 1, expHeader: 32'hA500_0001, expDoneCycle: 0, expWords: FRAME_LEN};
        applyStimulus(special, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
